// File: rtl/cache_core_plru_flush.sv
// N-way set-associative write-back, write-allocate cache with flop storage,
// tree-PLRU replacement (invalid ways filled first) and a full-cache flush
// that writes back every dirty line and reports completion with a pulse.
module cache_core_plru_flush #(
    parameter int S_LINE   = 256,
    parameter int S_INDEX  = 4,
    parameter int S_WAYIDX = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           mem_address,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [S_LINE/8-1:0]   mem_byte_enable,
    input  logic [S_LINE-1:0]     mem_wdata,
    output logic [S_LINE-1:0]     mem_rdata,
    output logic                  mem_resp,
    output logic [31:0]           pmem_address,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [S_LINE-1:0]     pmem_wdata,
    input  logic [S_LINE-1:0]     pmem_rdata,
    input  logic                  pmem_resp,
    input  logic                  flush_req,
    output logic                  flush_done
);

    localparam int S_MASK   = S_LINE / 8;
    localparam int S_OFF    = $clog2(S_MASK);
    localparam int S_TAG    = 32 - S_OFF - S_INDEX;
    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int NUM_WAYS = 2 ** S_WAYIDX;
    localparam int WAY_W    = (S_WAYIDX > 0) ? S_WAYIDX : 1;
    localparam int PLRU_W   = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;
    localparam int CNT_W    = S_INDEX + S_WAYIDX;

    typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH_SCAN, FLUSH_WB} state_t;

    state_t state, state_next;

    logic [S_TAG-1:0]    tag_mem   [NUM_SETS][NUM_WAYS];
    logic [S_LINE-1:0]   data_mem  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_mem [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_mem [NUM_SETS];
    logic [PLRU_W-1:0]   plru_mem  [NUM_SETS];

    logic [S_TAG-1:0]   req_tag;
    logic [S_INDEX-1:0] req_idx;
    logic               req;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   victim_sel;
    logic [WAY_W-1:0]   victim_q;
    logic [CNT_W-1:0]   cnt;
    logic [S_INDEX-1:0] fl_set;
    logic [WAY_W-1:0]   fl_way;
    logic               fl_dirty;
    logic               cnt_last;

    logic hit_access, hit_write, fill_done, latch_victim;
    logic cnt_clr, cnt_inc, flush_clear;

    // The CPU port is line-wide, so the byte offset never selects anything.
    logic unused_offset;
    assign unused_offset = ^mem_address[S_OFF-1:0];

    assign req_tag   = mem_address[31 -: S_TAG];
    assign req_idx   = mem_address[S_OFF +: S_INDEX];
    assign req       = mem_read | mem_write;
    assign hit_write = hit_access & mem_write;

    // Flush counter is set-major: upper bits pick the set, lower bits the way.
    assign fl_set   = cnt[CNT_W-1 -: S_INDEX];
    assign fl_way   = WAY_W'(cnt) & WAY_W'(NUM_WAYS - 1);
    assign fl_dirty = valid_mem[fl_set][fl_way] & dirty_mem[fl_set][fl_way];
    assign cnt_last = (cnt == {CNT_W{1'b1}});

    assign mem_rdata = data_mem[req_idx][hit_way];

    function automatic logic [S_LINE-1:0] merge_bytes(
        input logic [S_LINE-1:0] old_line,
        input logic [S_LINE-1:0] new_line,
        input logic [S_MASK-1:0] be
    );
        logic [S_LINE-1:0] r;
        r = old_line;
        for (int b = 0; b < S_MASK; b++) begin
            if (be[b]) r[8*b +: 8] = new_line[8*b +: 8];
        end
        return r;
    endfunction

    // Bit 0 at a node points left (lower ways), 1 points right.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] t);
        logic [WAY_W-1:0] w;
        int               n;
        logic             b;
        w = '0;
        n = 0;
        for (int l = 0; l < S_WAYIDX; l++) begin
            b = t[n];
            w = w | (WAY_W'(b) << (S_WAYIDX - 1 - l));
            n = 2 * n + (b ? 2 : 1);
        end
        return w;
    endfunction

    // Every node on the touched way's path is turned to point away from it.
    function automatic logic [PLRU_W-1:0] plru_touch(
        input logic [PLRU_W-1:0] t,
        input logic [WAY_W-1:0]  way
    );
        logic [PLRU_W-1:0] r;
        int                n;
        logic              b;
        r = t;
        n = 0;
        for (int l = 0; l < S_WAYIDX; l++) begin
            b    = way[S_WAYIDX - 1 - l];
            r[n] = ~b;
            n    = 2 * n + (b ? 2 : 1);
        end
        return r;
    endfunction

    // Tag compare qualified by valid, and victim choice (lowest invalid way, else PLRU).
    always_comb begin
        logic             inv_found;
        logic [WAY_W-1:0] inv_way;
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_mem[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_mem[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim_sel = inv_found ? inv_way : plru_victim(plru_mem[req_idx]);
    end

    // Controller next-state, handshakes and storage update strobes.
    always_comb begin
        state_next   = state;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        flush_done   = 1'b0;
        pmem_address = {req_tag, req_idx, {S_OFF{1'b0}}};
        pmem_wdata   = data_mem[req_idx][victim_q];
        hit_access   = 1'b0;
        fill_done    = 1'b0;
        latch_victim = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        flush_clear  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        mem_resp   = 1'b1;
                        hit_access = 1'b1;
                    end else begin
                        latch_victim = 1'b1;
                        if (valid_mem[req_idx][victim_sel] && dirty_mem[req_idx][victim_sel])
                            state_next = WB;
                        else
                            state_next = FILL;
                    end
                end else if (flush_req) begin
                    cnt_clr    = 1'b1;
                    state_next = FLUSH_SCAN;
                end
            end
            WB: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_mem[req_idx][victim_q], req_idx, {S_OFF{1'b0}}};
                if (pmem_resp) state_next = FILL;
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    fill_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            FLUSH_SCAN: begin
                pmem_address = {tag_mem[fl_set][fl_way], fl_set, {S_OFF{1'b0}}};
                pmem_wdata   = data_mem[fl_set][fl_way];
                if (fl_dirty) begin
                    state_next = FLUSH_WB;
                end else if (cnt_last) begin
                    flush_done = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            FLUSH_WB: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_mem[fl_set][fl_way], fl_set, {S_OFF{1'b0}}};
                pmem_wdata   = data_mem[fl_set][fl_way];
                if (pmem_resp) begin
                    flush_clear = 1'b1;
                    state_next  = FLUSH_SCAN;
                    // On the last entry the scan revisits it (now clean), so the
                    // completion pulse always comes out of FLUSH_SCAN.
                    if (!cnt_last) cnt_inc = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Tag and data arrays: written by CPU write hits and by line fills.
    always_ff @(posedge clk) begin
        if (hit_write)
            data_mem[req_idx][hit_way] <= merge_bytes(data_mem[req_idx][hit_way],
                                                      mem_wdata, mem_byte_enable);
        if (fill_done) begin
            data_mem[req_idx][victim_q] <= pmem_rdata;
            tag_mem[req_idx][victim_q]  <= req_tag;
        end
    end

    // State, valid/dirty/PLRU metadata, latched victim and flush counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            victim_q <= '0;
            cnt      <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
                plru_mem[s]  <= '0;
            end
        end else begin
            state <= state_next;
            if (latch_victim) victim_q <= victim_sel;
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
            if (hit_access) plru_mem[req_idx] <= plru_touch(plru_mem[req_idx], hit_way);
            if (hit_write)  dirty_mem[req_idx][hit_way] <= 1'b1;
            if (fill_done) begin
                valid_mem[req_idx][victim_q] <= 1'b1;
                dirty_mem[req_idx][victim_q] <= 1'b0;
            end
            if (flush_clear) dirty_mem[fl_set][fl_way] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_core_plru_flush.sv
// Directed bench for cache_core_plru_flush: the bench plays a one-cycle
// memory and compares CPU/memory traffic against hand-derived expectations.
module tb_cache_core_plru_flush;

    localparam int S_LINE   = 256;
    localparam int S_INDEX  = 4;
    localparam int S_WAYIDX = 2;
    localparam int S_MASK   = S_LINE / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [S_MASK-1:0] mem_byte_enable;
    logic [S_LINE-1:0] mem_wdata;
    logic [S_LINE-1:0] mem_rdata;
    logic              mem_resp;
    logic [31:0]       pmem_address;
    logic              pmem_read;
    logic              pmem_write;
    logic [S_LINE-1:0] pmem_wdata;
    logic [S_LINE-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              flush_req;
    logic              flush_done;

    always #5 clk = ~clk;

    cache_core_plru_flush #(
        .S_LINE(S_LINE), .S_INDEX(S_INDEX), .S_WAYIDX(S_WAYIDX)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .flush_req(flush_req), .flush_done(flush_done)
    );

    int errors = 0;
    int checks = 0;

    logic [S_LINE-1:0] mem_model [logic [31:0]];
    logic              op_wr   [$];
    logic [31:0]       op_addr [$];
    logic [S_LINE-1:0] op_data [$];
    logic [S_LINE-1:0] rd;
    int                lat;
    int                ndone;
    int                fdone_cyc;

    function automatic logic [S_LINE-1:0] pat(input logic [31:0] a);
        logic [S_LINE-1:0] r;
        for (int k = 0; k < S_LINE / 32; k++) r[32*k +: 32] = a ^ (32'hA500_0000 | 32'(k));
        return r;
    endfunction

    function automatic logic [S_LINE-1:0] model_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return pat(a);
    endfunction

    function automatic logic [31:0] opa(input int i);
        if (op_addr.size() > i) return op_addr[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic opw(input int i);
        if (op_wr.size() > i) return op_wr[i];
        return 1'bx;
    endfunction

    function automatic logic [S_LINE-1:0] opd(input int i);
        if (op_data.size() > i) return op_data[i];
        return 'x;
    endfunction

    task automatic chk(input string tag, input logic [S_LINE-1:0] obs, input logic [S_LINE-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        op_wr.delete();
        op_addr.delete();
        op_data.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; flush_req = 1'b0; pmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One CPU request, served by a single-cycle memory; called at a negedge.
    task automatic access(input logic [31:0] a, input logic wr,
                          input logic [S_MASK-1:0] be, input logic [S_LINE-1:0] wd);
        int cyc;
        bit done;
        clear_log();
        mem_address = a; mem_write = wr; mem_read = !wr;
        mem_byte_enable = be; mem_wdata = wd;
        cyc = 0; done = 1'b0; lat = -1; rd = '0;
        while (!done && cyc < 100) begin
            pmem_resp = 1'b0;
            #1;
            if (mem_resp) begin
                rd = mem_rdata; lat = cyc; done = 1'b1;
            end else if (pmem_read) begin
                op_wr.push_back(1'b0); op_addr.push_back(pmem_address); op_data.push_back('0);
                pmem_rdata = model_read(pmem_address);
                pmem_resp  = 1'b1;
            end else if (pmem_write) begin
                op_wr.push_back(1'b1); op_addr.push_back(pmem_address); op_data.push_back(pmem_wdata);
                mem_model[pmem_address] = pmem_wdata;
                pmem_resp = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        chk("access_completed", S_LINE'(done), S_LINE'(1));
    endtask

    task automatic flush();
        int cyc;
        bit fin;
        clear_log();
        ndone = 0; fdone_cyc = -1; flush_req = 1'b1; cyc = 0; fin = 1'b0;
        while (!fin && cyc < 500) begin
            pmem_resp = 1'b0;
            #1;
            if (flush_done) begin
                ndone++; fdone_cyc = cyc; fin = 1'b1; flush_req = 1'b0;
            end else if (pmem_write) begin
                op_wr.push_back(1'b1); op_addr.push_back(pmem_address); op_data.push_back(pmem_wdata);
                mem_model[pmem_address] = pmem_wdata;
                pmem_resp = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        flush_req = 1'b0; pmem_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (flush_done) ndone++;
            if (pmem_write) op_wr.push_back(1'b1);
            @(negedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [S_LINE-1:0] exp;
        logic [S_LINE-1:0] w0;
        logic [S_LINE-1:0] w1;
        logic [S_LINE-1:0] w2;
        rst = 1'b1; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_byte_enable = '0; mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0; flush_req = 1'b0;
        @(negedge clk);

        // Reset values and cold miss / re-read hit
        do_reset();
        #1;
        chk("rst_mem_resp", S_LINE'(mem_resp), '0);
        chk("rst_pmem_read", S_LINE'(pmem_read), '0);
        chk("rst_pmem_write", S_LINE'(pmem_write), '0);
        chk("rst_flush_done", S_LINE'(flush_done), '0);
        @(negedge clk);
        access(32'h0000_1000, 1'b0, '0, '0);
        chk("cold_latency", S_LINE'(lat), S_LINE'(2));
        chk("cold_ops", S_LINE'(op_addr.size()), S_LINE'(1));
        chk("cold_is_read", S_LINE'(opw(0)), '0);
        chk("cold_addr", S_LINE'(opa(0)), S_LINE'(32'h0000_1000));
        chk("cold_rdata", rd, pat(32'h0000_1000));
        access(32'h0000_1000, 1'b0, '0, '0);
        chk("reread_latency", S_LINE'(lat), '0);
        chk("reread_ops", S_LINE'(op_addr.size()), '0);
        chk("reread_rdata", rd, pat(32'h0000_1000));

        // Partial write hit, readback, and dirty line visible through a flush
        access(32'h0000_1000, 1'b1, 32'h0000_000F, '1);
        chk("whit_latency", S_LINE'(lat), '0);
        chk("whit_ops", S_LINE'(op_addr.size()), '0);
        exp = pat(32'h0000_1000);
        exp[31:0] = 32'hFFFF_FFFF;
        access(32'h0000_1000, 1'b0, '0, '0);
        chk("whit_readback", rd, exp);
        flush();
        chk("whit_flush_ops", S_LINE'(op_wr.size()), S_LINE'(1));
        chk("whit_flush_addr", S_LINE'(opa(0)), S_LINE'(32'h0000_1000));
        chk("whit_flush_data", opd(0), exp);
        chk("whit_flush_done", S_LINE'(ndone), S_LINE'(1));

        // PLRU: after touching way 0 again, way 2 (0x400) is the victim
        do_reset();
        access(32'h0000_0000, 1'b0, '0, '0);
        access(32'h0000_0200, 1'b0, '0, '0);
        access(32'h0000_0400, 1'b0, '0, '0);
        access(32'h0000_0600, 1'b0, '0, '0);
        access(32'h0000_0000, 1'b0, '0, '0);
        chk("plru_touch0_hit", S_LINE'(lat), '0);
        access(32'h0000_0800, 1'b0, '0, '0);
        chk("plru_0800_ops", S_LINE'(op_addr.size()), S_LINE'(1));
        chk("plru_0800_addr", S_LINE'(opa(0)), S_LINE'(32'h0000_0800));
        access(32'h0000_0400, 1'b0, '0, '0);
        chk("plru_0400_misses", S_LINE'(op_addr.size()), S_LINE'(1));
        chk("plru_0400_addr", S_LINE'(opa(0)), S_LINE'(32'h0000_0400));
        access(32'h0000_0000, 1'b0, '0, '0);
        chk("plru_0000_hits", S_LINE'(lat), '0);

        // Dirty eviction: writeback of way 0 precedes the fill
        do_reset();
        w0 = {8{32'hD1D2_D3D4}};
        access(32'h0000_0000, 1'b1, '1, w0);
        chk("evict_wmiss_ops", S_LINE'(op_addr.size()), S_LINE'(1));
        access(32'h0000_0200, 1'b0, '0, '0);
        access(32'h0000_0400, 1'b0, '0, '0);
        access(32'h0000_0600, 1'b0, '0, '0);
        access(32'h0000_0800, 1'b0, '0, '0);
        chk("evict_ops", S_LINE'(op_addr.size()), S_LINE'(2));
        chk("evict_first_is_write", S_LINE'(opw(0)), S_LINE'(1));
        chk("evict_wb_addr", S_LINE'(opa(0)), '0);
        chk("evict_wb_data", opd(0), w0);
        chk("evict_then_read", S_LINE'(opw(1)), '0);
        chk("evict_fill_addr", S_LINE'(opa(1)), S_LINE'(32'h0000_0800));
        chk("evict_latency", S_LINE'(lat), S_LINE'(3));
        chk("evict_rdata", rd, pat(32'h0000_0800));

        // Flush: dirty set 1 way 3 and set 5 way 0, then an empty flush
        do_reset();
        w1 = {8{32'h1357_9BDF}};
        w2 = {8{32'h2468_ACE0}};
        access(32'h0000_0020, 1'b0, '0, '0);
        access(32'h0000_0220, 1'b0, '0, '0);
        access(32'h0000_0420, 1'b0, '0, '0);
        access(32'h0000_0620, 1'b1, '1, w1);
        access(32'h0000_00A0, 1'b1, '1, w2);
        flush();
        chk("flush_ops", S_LINE'(op_wr.size()), S_LINE'(2));
        chk("flush_addr0", S_LINE'(opa(0)), S_LINE'(32'h0000_0620));
        chk("flush_data0", opd(0), w1);
        chk("flush_addr1", S_LINE'(opa(1)), S_LINE'(32'h0000_00A0));
        chk("flush_data1", opd(1), w2);
        chk("flush_done_count", S_LINE'(ndone), S_LINE'(1));
        flush();
        chk("flush2_ops", S_LINE'(op_wr.size()), '0);
        chk("flush2_done_count", S_LINE'(ndone), S_LINE'(1));
        chk("flush2_cycles", S_LINE'(fdone_cyc), S_LINE'(64));
        access(32'h0000_0620, 1'b0, '0, '0);
        chk("flush_lines_stay_valid", S_LINE'(lat), '0);

        // Reset during a fill abandons it and invalidates everything
        mem_address = 32'h0000_3000; mem_read = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (pmem_read) break;
            @(negedge clk);
        end
        chk("midfill_pmem_read", S_LINE'(pmem_read), S_LINE'(1));
        chk("midfill_addr", S_LINE'(pmem_address), S_LINE'(32'h0000_3000));
        rst = 1'b1; mem_read = 1'b0;
        @(posedge clk);
        #1;
        chk("midfill_abort", S_LINE'(pmem_read), '0);
        @(negedge clk);
        rst = 1'b0;
        access(32'h0000_3000, 1'b0, '0, '0);
        chk("midfill_remiss_ops", S_LINE'(op_addr.size()), S_LINE'(1));
        chk("midfill_remiss_addr", S_LINE'(opa(0)), S_LINE'(32'h0000_3000));
        access(32'h0000_0020, 1'b0, '0, '0);
        chk("midfill_old_line_misses", S_LINE'(op_addr.size()), S_LINE'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_core_plru_flush.md
Name: cache_core_plru_flush

Overview:
- Self-contained, parametrised N-way set-associative write-back, write-allocate cache.
- Integrates the controller FSM, flop-based tag/data/valid/dirty storage and a tree-PLRU, so it is generalised in line width, set count and way count.
- Sits between a CPU-side line-wide port and the line-wide physical memory / arbiter port.
- New behaviour:
  - Hit detection qualified by valid.
  - Invalid-way-first victim selection.
  - Integrated miss handling.
  - Full-cache flush (write back all dirty lines) with completion handshake.

Parameters:
S_LINE, 256, line width in bits; power of two, >=32; S_MASK = S_LINE/8; offset bits S_OFF = log2(S_LINE/8)
S_INDEX, 4, set index bits; NUM_SETS = 2**S_INDEX
S_WAYIDX, 2, way index bits; NUM_WAYS = 2**S_WAYIDX; 0 legal (direct-mapped); tag width S_TAG = 32-S_OFF-S_INDEX

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high; clock clk
mem_address  in  32  CPU byte address; offset bits ignored
mem_read  in  1  read request, held until mem_resp
mem_write  in  1  write request, held until mem_resp
mem_byte_enable  in  S_MASK  byte write mask
mem_wdata  in  S_LINE  write data
mem_rdata  out  S_LINE  read data, valid while mem_resp
mem_resp  out  1  request complete
pmem_address  out  32  line address, offset bits zero
pmem_read  out  1  line fill request, held until pmem_resp
pmem_write  out  1  line writeback request, held until pmem_resp
pmem_wdata  out  S_LINE  writeback data
pmem_rdata  in  S_LINE  fill data, valid with pmem_resp
pmem_resp  in  1  memory transaction complete
flush_req  in  1  level; request writeback of every dirty line
flush_done  out  1  one-cycle pulse at flush completion

Behaviour:
- Address split: tag = [31:S_OFF+S_INDEX], index = [S_OFF+S_INDEX-1:S_OFF].
- Hit: a valid way whose tag matches. At most one way matches by construction.
- Reset values and effects:
  - All valid, dirty and PLRU bits cleared; FSM in IDLE.
  - mem_resp, pmem_read, pmem_write and flush_done all 0.
  - Tag and data contents are don't-care.
- Reset mid-operation: any in-flight fill, writeback or flush is abandoned; the next cycle is IDLE.
- States: IDLE, WB, FILL, FLUSH_SCAN, FLUSH_WB.
- IDLE with mem_read or mem_write:
  - Hit:
    - mem_resp=1 combinationally in the same cycle; mem_rdata = hit line.
    - Write: on that edge, bytes with mem_byte_enable=1 are written and dirty is set.
    - PLRU updated on that edge for both reads and writes.
  - Miss, victim selection: lowest-index invalid way; if none, the PLRU way. Victim way is latched.
  - Miss transitions: victim valid and dirty -> WB, otherwise -> FILL. mem_resp stays 0.
  - mem_read and mem_write together: treated as a write.
- WB:
  - pmem_write=1, pmem_address={victim tag, index, 0}, pmem_wdata = victim line.
  - On pmem_resp -> FILL.
- FILL:
  - pmem_read=1, pmem_address={request tag, index, 0}.
  - On pmem_resp: victim data=pmem_rdata, tag written, valid=1, dirty=0 -> IDLE.
  - The held request then hits. Miss latency = memory cycles + 1; no pmem activity during a hit.
- PLRU: NUM_WAYS-1 bits per set, binary tree.
  - On access, every node on the accessed way's path is set to point away from it.
  - Victim: follow node pointers from the root.
  - S_WAYIDX=0: no PLRU bits; victim is way 0.
- Flush:
  - Accepted only in IDLE with no mem request; CPU requests have priority.
  - FLUSH_SCAN walks a {set, way} counter from 0 to NUM_SETS*NUM_WAYS-1, set-major, ascending, one entry per cycle.
  - Valid and dirty entry -> FLUSH_WB: pmem_write of that line; on pmem_resp clear dirty, resume the scan at the next entry.
  - After the last entry: flush_done=1 for one cycle, then IDLE.
  - Lines stay valid; PLRU unchanged.
  - flush_req still high at completion starts a new flush only after one IDLE cycle.
- pmem_resp outside WB/FILL/FLUSH_WB is ignored.
- Changing mem_address while mem_resp=0 after a request has started is illegal; behaviour is undefined.

Test Plan:
- Defaults. Cold read 0x0000_1000 -> pmem_read with pmem_address 0x0000_1000; pmem_resp with data D -> next cycle mem_resp=1, mem_rdata=D. Re-read -> mem_resp in the same cycle, pmem_read stays 0.
- Write hit to 0x1000: mem_byte_enable=0x0000_000F, wdata all 0xFF -> readback bytes 3:0 = 0xFF, bytes 31:4 = D; line dirty.
- PLRU: reads of 0x000, 0x200, 0x400, 0x600 (set 0, ways 0-3), then 0x000 again, then 0x800 -> the 0x400 line (way 2) is evicted. Re-read 0x400 misses; 0x000 hits.
- Dirty eviction: write 0x000, then fill set 0 until way 0 is the victim -> pmem_write to 0x0000_0000 with the written data completes before pmem_read of the new line.
- Flush with dirty lines at set 1 way 3 and set 5 way 0 -> exactly two pmem_writes, in the order set 1 then set 5; flush_done pulses once. A second flush gives zero writes and flush_done after 64 scan cycles.
- rst asserted mid-FILL -> pmem_read=0 the next cycle, all lines invalid; the previous address misses again.
